// File: rtl/segment_shader_if.sv
// segment_shader_if: pixel stream, lit-bit write port and status outputs of segment_shader
interface segment_shader_if;
  logic        vblank;
  logic        has_segment;
  logic [9:0]  segment_id;
  logic [23:0] bg_rgb;
  logic        seg_wr;
  logic [9:0]  seg_wr_id;
  logic        seg_wr_on;
  logic [23:0] rgb_out;
  logic        ready;
  logic        sweep_overrun;
  modport master (
    output vblank, has_segment, segment_id, bg_rgb, seg_wr, seg_wr_id, seg_wr_on,
    input  rgb_out, ready, sweep_overrun
  );
  modport slave (
    input  vblank, has_segment, segment_id, bg_rgb, seg_wr, seg_wr_id, seg_wr_on,
    output rgb_out, ready, sweep_overrun
  );
endinterface

// File: rtl/segment_shader.sv
// segment_shader: blends LCD segment colour over background art; SEGMENT_SHADER_GHOSTING_EN adds level RAM with vblank decay sweep
module segment_shader #(
  parameter int FADE_BITS = 4,
`ifdef SEGMENT_SHADER_GHOSTING_EN
  parameter int DECAY = 3,
`endif
  parameter logic [23:0] SEG_COLOR = 24'h101010
) (
  input logic clk,
  input logic reset,
  segment_shader_if.slave s
);
  localparam logic [FADE_BITS:0] ONE = {1'b1, {FADE_BITS{1'b0}}};
  localparam int AW = FADE_BITS + 9;
  localparam logic [1:0] CLEAR = 2'd0, IDLE = 2'd1;
`ifdef SEGMENT_SHADER_GHOSTING_EN
  localparam logic [1:0] SW_RD = 2'd2, SW_WR = 2'd3;
  localparam logic [FADE_BITS:0] DEC = DECAY[FADE_BITS:0];
`endif
  logic [1:0] state;
  logic [9:0] idx;
  logic lit [1024];
  logic lit_q;
  logic hs1;
  logic owns;
  logic [23:0] bg1;
  logic [FADE_BITS:0] w;
  logic [23:0] blend;
  assign owns = s.vblank || state != IDLE;
  always_ff @(posedge clk) begin
    if (state == CLEAR) lit[idx] <= 1'b0;
    if (s.seg_wr && (state != CLEAR || s.seg_wr_id < idx)) lit[s.seg_wr_id] <= s.seg_wr_on;
  end
`ifdef SEGMENT_SHADER_GHOSTING_EN
  logic [FADE_BITS:0] level [1024];
  logic [FADE_BITS:0] level_q, new_level;
  logic vb_q;
  // one shared level port: the sweep/clear owns it whenever the pixel path is forced to w=0
  always_ff @(posedge clk) begin
    level_q <= level[owns ? idx : s.segment_id];
    if (state == CLEAR || (state == SW_WR && s.vblank)) level[idx] <= state == CLEAR ? '0 : new_level;
  end
  always_comb new_level = lit_q ? ONE : level_q > DEC ? level_q - DEC : '0;
  assign w = hs1 ? level_q : '0;
`else
  always_ff @(posedge clk) lit_q <= lit[s.segment_id];
  assign w = hs1 && lit_q ? ONE : '0;
  assign s.sweep_overrun = 1'b0;
`endif
  always_ff @(posedge clk) begin
    hs1 <= s.has_segment && !owns;
    bg1 <= s.bg_rgb;
    s.rgb_out <= reset ? '0 : blend;
  end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign blend[8*c +: 8] = 8'((AW'(bg1[8*c +: 8]) * AW'(ONE - w) + AW'(SEG_COLOR[8*c +: 8]) * AW'(w)) >> FADE_BITS);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      idx <= '0;
      s.ready <= 1'b0;
`ifdef SEGMENT_SHADER_GHOSTING_EN
      s.sweep_overrun <= 1'b0;
      vb_q <= 1'b0;
`endif
    end else begin
`ifdef SEGMENT_SHADER_GHOSTING_EN
      vb_q <= s.vblank;
      s.sweep_overrun <= 1'b0;
`endif
      case (state)
        CLEAR: begin
          idx <= idx + 10'd1;
          if (&idx) begin
            s.ready <= 1'b1;
            state <= IDLE;
          end
        end
`ifdef SEGMENT_SHADER_GHOSTING_EN
        IDLE: if (s.vblank && !vb_q) begin
          idx <= '0;
          state <= SW_RD;
        end
        SW_RD, SW_WR: if (!s.vblank) begin
          state <= IDLE;
          s.sweep_overrun <= 1'b1;
        end else if (state == SW_RD) begin
          lit_q <= lit[idx];
          state <= SW_WR;
        end else begin
          idx <= idx + 10'd1;
          state <= &idx ? IDLE : SW_RD;
        end
`else
        IDLE: state <= IDLE;
`endif
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_segment_shader.sv
// tb_segment_shader: directed + randomized checks of segment_shader against an array-based reference model
module tb_segment_shader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  segment_shader_if bus();
  segment_shader dut (.clk(clk), .reset(reset), .s(bus));
  always #5 clk = ~clk;
  localparam logic [23:0] SEG = 24'h101010;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_lit [1024];
  int m_level [1024];
  logic [23:0] q [$];
  function automatic int wt(int id, bit hs);
    if (!hs) return 0;
`ifdef SEGMENT_SHADER_GHOSTING_EN
    return m_level[id];
`else
    return m_lit[id] ? 16 : 0;
`endif
  endfunction
  function automatic logic [23:0] shade(logic [23:0] bg, int w);
    logic [23:0] r;
    logic [23:0] sc;
    sc = SEG;
    for (int c = 0; c < 3; c++)
      r[8*c +: 8] = 8'((int'(bg[8*c +: 8]) * (16 - w) + int'(sc[8*c +: 8]) * w) / 16);
    return r;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(string tag, logic [23:0] got, logic [23:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear_wait;
    int n;
    n = 0;
    foreach (m_lit[i]) begin
      m_lit[i] = 0;
      m_level[i] = 0;
    end
    reset = 1;
    tick;
    check("rst_rgb", bus.rgb_out, 24'h0);
    check("rst_ready", 24'(bus.ready), 24'h0);
    check("rst_ovr", 24'(bus.sweep_overrun), 24'h0);
    reset = 0;
    while (!bus.ready && n < 2000) begin
      bus.seg_wr = (n == 100 || n == 200 || n == 300);
      bus.seg_wr_id = n == 100 ? 10'd50 : n == 200 ? 10'd200 : 10'd700;
      bus.seg_wr_on = 1;
      tick;
      n++;
    end
    bus.seg_wr = 0;
    m_lit[50] = 1;
    check("clear_cycles", 24'(n), 24'd1024);
    check("ready", 24'(bus.ready), 24'h1);
  endtask
  task automatic px(string tag, int id, bit hs, logic [23:0] bg);
    bus.segment_id = 10'(id);
    bus.has_segment = hs;
    bus.bg_rgb = bg;
    tick;
    bus.has_segment = 0;
    tick;
    check(tag, bus.rgb_out, shade(bg, wt(id, hs)));
  endtask
  task automatic wr(int id, bit on);
    bus.seg_wr = 1;
    bus.seg_wr_id = 10'(id);
    bus.seg_wr_on = on;
    tick;
    bus.seg_wr = 0;
    m_lit[id] = on;
  endtask
`ifdef SEGMENT_SHADER_GHOSTING_EN
  task automatic frame(int len, int upto, int exp_ovr);
    int ovr;
    ovr = 0;
    bus.vblank = 1;
    for (int t = 0; t < len; t++) begin
      bus.has_segment = (t == 10);
      bus.segment_id = 10'd5;
      bus.bg_rgb = 24'h123456;
      tick;
      if (t == 11) check("vblank_bypass", bus.rgb_out, 24'h123456);
      ovr += int'(bus.sweep_overrun);
    end
    bus.vblank = 0;
    bus.has_segment = 0;
    repeat (4) begin
      tick;
      ovr += int'(bus.sweep_overrun);
    end
    check("overrun_pulses", 24'(ovr), 24'(exp_ovr));
    for (int i = 0; i < upto; i++)
      m_level[i] = m_lit[i] ? 16 : m_level[i] > 3 ? m_level[i] - 3 : 0;
  endtask
`endif
  initial begin
    int id;
    bit hs;
    logic [23:0] bg;
    bus.vblank = 0;
    bus.has_segment = 0;
    bus.segment_id = '0;
    bus.bg_rgb = '0;
    bus.seg_wr = 0;
    bus.seg_wr_id = '0;
    bus.seg_wr_on = 0;
    clear_wait();
    px("bg_after_clear", 5, 1, 24'hC0C0C0);
    px("clear_accept", 50, 1, 24'h808080);
    px("clear_wins", 200, 1, 24'h808080);
    wr(7, 1);
    px("lit_on", 7, 1, 24'hAAAAAA);
    px("hs_off", 7, 0, 24'hAAAAAA);
    wr(7, 0);
    px("lit_off", 7, 1, 24'hAAAAAA);
    for (int t = 0; t < 300; t++) begin
      id = int'($urandom_range(0, 15));
      hs = 1'($urandom);
      bg = 24'($urandom);
      bus.segment_id = 10'(id);
      bus.has_segment = hs;
      bus.bg_rgb = bg;
      q.push_back(shade(bg, wt(id, hs)));
      bus.seg_wr = 1'($urandom);
      bus.seg_wr_id = 10'($urandom_range(0, 15));
      bus.seg_wr_on = 1'($urandom);
      tick;
      if (bus.seg_wr) m_lit[bus.seg_wr_id] = bus.seg_wr_on;
      if (q.size() == 2) check("rand_px", bus.rgb_out, q.pop_front());
    end
    bus.seg_wr = 0;
    bus.has_segment = 0;
    tick;
    check("rand_px_last", bus.rgb_out, q.pop_front());
`ifdef SEGMENT_SHADER_GHOSTING_EN
    wr(5, 1);
    frame(2100, 1024, 0);
    px("lit_full", 5, 1, 24'hF0F0F0);
    px("lit_hs0", 5, 0, 24'hF0F0F0);
    wr(5, 0);
    for (int f = 0; f < 7; f++) begin
      frame(2100, 1024, 0);
      px("decay", 5, 1, 24'hF0F0F0);
      if (f == 1) check("level10", bus.rgb_out, 24'h646464);
    end
    wr(900, 1);
    frame(2100, 1024, 0);
    wr(900, 0);
    wr(5, 1);
    frame(1000, 400, 1);
    px("ovr_swept", 5, 1, 24'hF0F0F0);
    px("ovr_kept", 900, 1, 24'hF0F0F0);
    bus.vblank = 1;
    repeat (601) tick;
    bus.vblank = 0;
    clear_wait();
    frame(2100, 1024, 0);
`else
    wr(9, 1);
    reset = 1;
    tick;
    reset = 0;
    repeat (500) tick;
    clear_wait();
`endif
    px("post_reset_5", 5, 1, 24'hF0F0F0);
    px("post_reset_9", 9, 1, 24'h3C3C3C);
    px("post_reset_900", 900, 1, 24'hF0F0F0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/segment_shader.md
Name: segment_shader

Overview:
- Sits directly downstream of the mask pixel-selection stage.
- Consumes the per-pixel segment_id/has_segment stream and the background artwork pixel, looks up each segment's brightness level and blends the segment colour over the background.
- Keeps a per-segment lit bit written by the CPU/LCD-RAM side.
- Runs a once-per-frame sweep during vblank that turns lit bits into decaying brightness levels (LCD persistence).

Parameters:
- FADE_BITS, 4: fractional weight width. Level range 0..2^FADE_BITS, stored in FADE_BITS+1 bits.
- DECAY, 3: level subtracted per frame from an unlit segment.
- SEG_COLOR, 24'h101010: RGB888 colour of a fully lit segment.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- vblank  in  1  vertical blank from video timing
- has_segment  in  1  current pixel belongs to a segment (from mask stage)
- segment_id  in  10  segment index for current pixel
- bg_rgb  in  24  background pixel aligned with has_segment/segment_id
- seg_wr  in  1  lit-bit write strobe
- seg_wr_id  in  10  lit-bit write index
- seg_wr_on  in  1  lit-bit value
- rgb_out  out  24  shaded pixel
- ready  out  1  clear sweep finished
- sweep_overrun  out  1  one-cycle pulse: frame sweep aborted by vblank fall

Behaviour:
- Reset is clk, synchronous, active-high.
- Storage:
  - lit[1024] x1: write port owned by seg_wr; write takes effect next cycle.
  - level[1024] x(FADE_BITS+1): single-port, owned by the FSM.
- Reset values: rgb_out=0, ready=0, sweep_overrun=0, FSM=CLEAR, sweep index=0.
- FSM states:
  - CLEAR: writes lit=0 and level=0 at one index per cycle, 0..1023 (1024 cycles). Then ready<=1, go to IDLE.
  - IDLE: a vblank rising edge goes to SW_RD with index 0.
  - SW_RD: read level[idx] and lit[idx].
  - SW_WR: write the new level.
    - If lit=1: new = 2^FADE_BITS.
    - If lit=0 and level>DECAY: new = level-DECAY.
    - Otherwise: new = 0. No underflow.
    - idx==1023: go to IDLE. Otherwise idx+1, go to SW_RD.
    - A full sweep is 2048 cycles.
- Vblank fall during SW_RD/SW_WR:
  - Sweep aborts and goes to IDLE; the pending write is dropped.
  - Entries not reached keep their old level.
  - sweep_overrun pulses for 1 cycle.
- Reset asserted mid-sweep or mid-clear: restarts CLEAR from index 0 and drops ready.
- seg_wr during CLEAR:
  - Ignored if its index has not yet been cleared. CLEAR wins on the same index.
  - Accepted if the index was already cleared.
- seg_wr and sweep read of the same index in the same cycle: the sweep sees the old value.
- Pixel path (pipeline advances every clk, latency 2 cycles):
  - Stage 1: level RAM read at segment_id. Capture has_segment and bg_rgb.
  - Stage 2, per 8-bit channel: out = (bg*(2^F - w) + SEG_COLOR_ch*w) >> F, where w = level if has_segment else 0. Intermediate is 8+F+1 bits; the result fits in 8 bits.
  - w=0 gives exactly bg; w=2^F gives exactly SEG_COLOR.
- Pixel path during vblank or CLEAR: the level port belongs to the FSM, w is forced to 0, and rgb_out=bg_rgb delayed 2 cycles.

Optional Feature:
- Macro SEGMENT_SHADER_GHOSTING_EN.
- Defined: level RAM, decay sweep and sweep_overrun exist as above.
- Undefined:
  - No level RAM and no sweep.
  - w = lit[segment_id] ? 2^F : 0, read from lit in stage 1.
  - sweep_overrun tied 0.
  - CLEAR still clears lit over 1024 cycles.
  - Pixel latency remains 2 cycles.

Test Plan:
1. Reset 1 cycle, hold 1030 cycles -> ready=1 exactly 1024 cycles after reset deassert; a following pixel with has_segment=1, id=5, bg=24'hC0C0C0 gives rgb_out=24'hC0C0C0 two cycles later.
2. seg_wr id=5 on=1, vblank pulse 2100 cycles -> next frame pixel id=5, has_segment=1, bg=24'hF0F0F0 gives rgb_out=24'h101010; same pixel with has_segment=0 gives 24'hF0F0F0.
3. Decay: after test 2, write id=5 off, run 3 frames -> level 16,13,10,7. At level 10, bg=24'hF0F0F0 gives channel (240*6+16*10)>>4=100, so 24'h646464. Frames continue to 4,1,0 and hold at 0.
4. Overrun: vblank only 1000 cycles -> sweep_overrun pulses once at vblank fall; entries 500..1023 keep prior levels (check id=900 unchanged).
5. Reset at sweep index 300 -> ready drops; all levels read 0 after the new CLEAR; lit bits 0.
6. Ghosting disabled build: seg_wr id=7 on=1 -> next cycle pixel id=7 shows SEG_COLOR after 2-cycle latency with no vblank needed; off -> bg immediately.
